// File: rtl/morse_pkg.sv
// Shared types, code constants, timing multipliers and the Morse character table
// used by the encoder and its lookup ROM.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_GAP  = 2'd2,
        ST_CGAP = 2'd3
    } state_t;

    localparam logic [5:0] CODE_SPACE     = 6'd63;
    localparam logic [5:0] CODE_MAX_VALID = 6'd35;

    localparam int unsigned DOT_UNITS      = 1;
    localparam int unsigned DASH_UNITS     = 3;
    localparam int unsigned ELEM_GAP_UNITS = 1;
    localparam int unsigned CHAR_GAP_UNITS = 3;
    localparam int unsigned WORD_GAP_UNITS = 7;

    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_sym_t;

    // Pattern is left-aligned: bit 4 is the first element, 1 = dash.
    function automatic morse_sym_t morse_lookup(input logic [5:0] code);
        logic [7:0] lp;
        case (code)
            6'd0:    lp = {3'd2, 5'b01000};
            6'd1:    lp = {3'd4, 5'b10000};
            6'd2:    lp = {3'd4, 5'b10100};
            6'd3:    lp = {3'd3, 5'b10000};
            6'd4:    lp = {3'd1, 5'b00000};
            6'd5:    lp = {3'd4, 5'b00100};
            6'd6:    lp = {3'd3, 5'b11000};
            6'd7:    lp = {3'd4, 5'b00000};
            6'd8:    lp = {3'd2, 5'b00000};
            6'd9:    lp = {3'd4, 5'b01110};
            6'd10:   lp = {3'd3, 5'b10100};
            6'd11:   lp = {3'd4, 5'b01000};
            6'd12:   lp = {3'd2, 5'b11000};
            6'd13:   lp = {3'd2, 5'b10000};
            6'd14:   lp = {3'd3, 5'b11100};
            6'd15:   lp = {3'd4, 5'b01100};
            6'd16:   lp = {3'd4, 5'b11010};
            6'd17:   lp = {3'd3, 5'b01000};
            6'd18:   lp = {3'd3, 5'b00000};
            6'd19:   lp = {3'd1, 5'b10000};
            6'd20:   lp = {3'd3, 5'b00100};
            6'd21:   lp = {3'd4, 5'b00010};
            6'd22:   lp = {3'd3, 5'b01100};
            6'd23:   lp = {3'd4, 5'b10010};
            6'd24:   lp = {3'd4, 5'b10110};
            6'd25:   lp = {3'd4, 5'b11000};
            6'd26:   lp = {3'd5, 5'b11111};
            6'd27:   lp = {3'd5, 5'b01111};
            6'd28:   lp = {3'd5, 5'b00111};
            6'd29:   lp = {3'd5, 5'b00011};
            6'd30:   lp = {3'd5, 5'b00001};
            6'd31:   lp = {3'd5, 5'b00000};
            6'd32:   lp = {3'd5, 5'b10000};
            6'd33:   lp = {3'd5, 5'b11000};
            6'd34:   lp = {3'd5, 5'b11100};
            6'd35:   lp = {3'd5, 5'b11110};
            default: lp = 8'h00;
        endcase
        return morse_sym_t'({(code <= CODE_MAX_VALID), lp});
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational code-to-(length, pattern) lookup built on the package table.
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] i_code,
    output logic       o_valid,
    output logic [2:0] o_len,
    output logic [4:0] o_pat
);

    morse_sym_t w_sym;

    assign w_sym   = morse_lookup(i_code);
    assign o_valid = w_sym.valid;
    assign o_len   = w_sym.len;
    assign o_pat   = w_sym.pat;

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: one character per request, timed in units of UNIT_CYCLES clocks.
// Handshake: a request is taken on any rising edge where in_valid and in_ready are both high.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 10000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_code,
    output logic       in_ready,
    input  logic       abort,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output state_t     dbg_state
);

    localparam int unsigned CNT_W = $clog2(WORD_GAP_UNITS * UNIT_CYCLES);

    localparam logic [CNT_W-1:0] LD_DOT  = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DASH = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_ELEM = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CHAR = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WORD = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_load;
    logic [4:0]         r_pat;
    logic [2:0]         r_left;
    logic               r_key;
    logic               r_done;
    logic               r_err;

    logic               w_rom_valid;
    logic [2:0]         w_rom_len;
    logic [4:0]         w_rom_pat;
    logic               w_accept;
    logic               w_start_char;
    logic               w_start_space;
    logic               w_bad_code;
    logic               w_abort;
    logic               w_expire;
    logic               w_next_dash;
    logic               w_key_next;
    logic               w_done_next;
    logic               w_err_next;

    morse_rom u_rom (
        .i_code  (in_code),
        .o_valid (w_rom_valid),
        .o_len   (w_rom_len),
        .o_pat   (w_rom_pat)
    );

    assign w_accept      = in_valid && (r_state == ST_IDLE);
    assign w_start_char  = w_accept && w_rom_valid;
    assign w_start_space = w_accept && (in_code == CODE_SPACE);
    assign w_bad_code    = w_accept && !w_rom_valid && (in_code != CODE_SPACE);
    assign w_abort       = abort && (r_state != ST_IDLE);
    assign w_expire      = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_left  <= '0;
            r_key   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            // Reload on every state change so the count never wraps inside a state.
            if (w_state_next != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (!w_expire) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_start_char) begin
                r_pat  <= w_rom_pat;
                r_left <= w_rom_len;
            end else if (r_state == ST_MARK && w_state_next == ST_GAP) begin
                r_pat  <= {r_pat[3:0], 1'b0};
                r_left <= r_left - 3'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_char) begin
                    w_state_next = ST_MARK;
                end else if (w_start_space) begin
                    w_state_next = ST_CGAP;
                end
            end
            ST_MARK: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_expire) begin
                    w_state_next = (r_left == 3'd1) ? ST_CGAP : ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_expire) begin
                    w_state_next = ST_MARK;
                end
            end
            ST_CGAP: begin
                if (w_abort || w_expire) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The element about to be keyed: straight from the ROM on a fresh request,
    // otherwise the head of the already-shifted pattern.
    assign w_next_dash = (r_state == ST_IDLE) ? w_rom_pat[4] : r_pat[4];

    always_comb begin
        w_cnt_load  = '0;
        w_key_next  = (w_state_next == ST_MARK);
        w_done_next = (r_state == ST_CGAP) && w_expire && !w_abort;
        w_err_next  = w_bad_code;
        case (w_state_next)
            ST_MARK: w_cnt_load = w_next_dash ? LD_DASH : LD_DOT;
            ST_GAP:  w_cnt_load = LD_ELEM;
            ST_CGAP: w_cnt_load = (r_state == ST_IDLE) ? LD_WORD : LD_CHAR;
            default: w_cnt_load = '0;
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = !in_ready;
    assign key_out   = r_key;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder at UNIT_CYCLES=4: the key line is reduced to
// mark/gap/done/err events and compared against hand-computed expectations.
module tb_morse_encoder;
    import morse_pkg::*;

    localparam int unsigned UNIT = 4;
    localparam int          W    = 16;
    localparam logic [3:0]  EV_MARK = 4'd1;
    localparam logic [3:0]  EV_GAP  = 4'd2;
    localparam logic [3:0]  EV_DONE = 4'd3;
    localparam logic [3:0]  EV_ERR  = 4'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_code = 6'd0;
    logic       abort = 1'b0;
    logic       in_ready;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    int   hi_cnt   = 0;
    int   low_cnt  = 0;
    logic prev_key = 1'b0;

    morse_encoder #(.UNIT_CYCLES(UNIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .abort     (abort),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic [3:0] kind, input int n);
        return {kind, 12'(n)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] kind, input int n);
        exp_q.push_back(ev(kind, n));
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic observe(input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d len=%0d, required no event",
                     obs[15:12], obs[11:0]);
        end else begin
            e = exp_q.pop_front();
            if (obs != e) begin
                n_fail++;
                $display("FAIL event: got kind=%0d len=%0d, required kind=%0d len=%0d",
                         obs[15:12], obs[11:0], e[15:12], e[11:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            observe(ev(EV_DONE, low_cnt));
            check("done_with_ready", int'(in_ready), 1);
            low_cnt = 0;
        end
        if (key_out) begin
            if (!prev_key) begin
                if (low_cnt > 0) observe(ev(EV_GAP, low_cnt));
                low_cnt = 0;
            end
            hi_cnt++;
        end else begin
            if (prev_key) begin
                observe(ev(EV_MARK, hi_cnt));
                hi_cnt = 0;
            end
            if (!done) low_cnt++;
        end
        if (err) observe(ev(EV_ERR, 0));
        if (rst_n && in_valid && in_ready) low_cnt = 0;
        prev_key = key_out;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: in_ready=0 after 300 cycles, required 1");
        end
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: done=0 after 400 cycles, required 1");
        end
    endtask

    task automatic send(input logic [5:0] code);
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_key", int'(key_out), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_state", int'(dbg_state), int'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 'E'
        push(EV_MARK, 4); push(EV_DONE, 12);
        send(6'd4);
        wait_done();

        // 'A'
        push(EV_MARK, 4); push(EV_GAP, 4); push(EV_MARK, 12); push(EV_DONE, 12);
        send(6'd0);
        wait_done();

        // word space
        push(EV_DONE, 28);
        send(6'd63);
        wait_done();

        // invalid codes, including both ends of the invalid range
        push(EV_ERR, 0);
        send(6'd40);
        repeat (2) @(negedge clk);
        check("err_ready_40", int'(in_ready), 1);
        check("err_one_cycle", int'(err), 0);
        push(EV_ERR, 0);
        send(6'd36);
        push(EV_ERR, 0);
        send(6'd62);
        repeat (2) @(negedge clk);
        check("err_ready_62", int'(in_ready), 1);

        // 'Z' and '9' (highest valid code)
        push(EV_MARK, 12); push(EV_GAP, 4); push(EV_MARK, 12); push(EV_GAP, 4);
        push(EV_MARK, 4);  push(EV_GAP, 4); push(EV_MARK, 4);  push(EV_DONE, 12);
        send(6'd25);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            push(EV_MARK, 12); push(EV_GAP, 4);
        end
        push(EV_MARK, 4); push(EV_DONE, 12);
        send(6'd35);
        wait_done();

        // back-to-back 'T' with in_valid held
        push(EV_MARK, 12); push(EV_DONE, 12); push(EV_MARK, 12); push(EV_DONE, 12);
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_code  = 6'd19;
        wait_done();
        @(negedge clk);
        check("b2b_key_after_idle", int'(key_out), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();

        // in_valid while busy is ignored
        push(EV_MARK, 4); push(EV_DONE, 12);
        send(6'd4);
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_code  = 6'd40;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();

        // abort in the middle of the second dash of 'O'
        push(EV_MARK, 12); push(EV_GAP, 4); push(EV_MARK, 5);
        send(6'd14);
        repeat (20) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_ready", int'(in_ready), 1);
        check("abort_key", int'(key_out), 0);
        check("abort_busy", int'(busy), 0);

        // abort on the same edge as the character-gap expiry: no done
        push(EV_MARK, 4);
        send(6'd4);
        repeat (15) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_expiry_done", int'(done), 0);
        check("abort_expiry_ready", int'(in_ready), 1);

        // abort while idle has no effect
        wait_ready();
        @(posedge clk);
        #1;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ready", int'(in_ready), 1);
        push(EV_MARK, 4); push(EV_DONE, 12);
        send(6'd4);
        wait_done();

        // reset mid-dash of '0', then 'E' taken on the first edge after release
        push(EV_MARK, 6);
        send(6'd26);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_key", int'(key_out), 0);
        check("midrst_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        in_valid = 1'b1;
        in_code  = 6'd4;
        push(EV_MARK, 4); push(EV_DONE, 12);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_accept_key", int'(key_out), 1);
        wait_done();

        wait_ready();
        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 10000, giving the clock cycles per Morse time unit (100 us at 100 MHz); legal range 1 to 2^20-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: character request.
REQ-005 SHALL have port in_code, input, 6 bits: character code; 0-25 = A-Z, 26-35 = digits 0-9, 63 = word space, 36-62 invalid.
REQ-006 SHALL have port in_ready, output, 1 bit: encoder idle, request acceptable.
REQ-007 SHALL have port abort, input, 1 bit: synchronous cancel of the current character.
REQ-008 SHALL have port key_out, output, 1 bit: keyed Morse signal, high = mark.
REQ-009 SHALL have port busy, output, 1 bit: a character is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a character, including its trailing gap, completes.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse when an invalid code is presented.

Function
REQ-012 SHALL accept a request on the rising edge where in_valid and in_ready are both high; in_code is captured on that edge.
REQ-013 SHALL use states IDLE, MARK, GAP, CGAP; in_ready = (state==IDLE), busy = !in_ready.
REQ-014 SHALL look up each valid code as length (1-5) and pattern (5 bits, MSB-first, 1 = dash), using the international Morse table.
REQ-015 SHALL, on accepting a letter or digit, enter MARK with key_out high from the next cycle.
REQ-016 SHALL hold each dot mark for exactly 1*UNIT_CYCLES cycles and each dash mark for exactly 3*UNIT_CYCLES cycles.
REQ-017 SHALL, after a mark that is not the last element, go to GAP with key_out low for exactly 1*UNIT_CYCLES cycles, then to MARK for the next element.
REQ-018 SHALL, after the last mark, go to CGAP with key_out low for exactly 3*UNIT_CYCLES cycles.
REQ-019 SHALL, on accepting code 63, go directly to CGAP with key_out low for exactly 7*UNIT_CYCLES cycles.
REQ-020 SHALL, at the end of CGAP, pulse done for one cycle and return to IDLE, with in_ready high in the same cycle as done.
REQ-021 SHALL NOT accept a new request in the cycle done is high; the earliest acceptance is the next edge.
REQ-022 SHALL, for an invalid code (36-62) presented while IDLE, pulse err for one cycle, stay IDLE, leave key_out low and not pulse done.
REQ-023 SHALL ignore in_valid while busy: no queuing and no err.
REQ-024 SHALL, on abort while busy, drive key_out low and return to IDLE on the next edge with no done pulse.
REQ-025 SHALL ignore abort while IDLE.
REQ-026 SHALL give abort priority over timer expiry when both occur in the same cycle.
REQ-027 SHALL use a unit counter sized to hold 7*UNIT_CYCLES-1, reloaded on every state change, with no wrap-around inside a state.
REQ-028 SHALL register key_out directly from a flop, with no combinational path from inputs.

Reset
REQ-029 SHALL, while rst_n is low, immediately force state=IDLE, key_out=0, done=0, err=0, busy=0, in_ready=1, and clear all counters.
REQ-030 SHALL, on reset mid-character, drop key_out at once, emit no done, and accept a request on the first edge after rst_n deasserts.

Structure
REQ-031 SHALL place the state enum, code constants (CODE_SPACE=63, CODE_MAX_VALID=35) and the gap multipliers (1/3/7) in the shared package morse_pkg.
REQ-032 SHALL implement the code-to-(length, pattern) lookup as the combinational sub-module morse_rom, with the decoder reusing the same package table.

Verification (UNIT_CYCLES=4)
REQ-033 SHALL test: code 4 ('E') -> key high 4 cycles, low 12, done pulse, in_ready high.
REQ-034 SHALL test: code 0 ('A') -> key high 4, low 4, high 12, low 12, then done.
REQ-035 SHALL test: code 63 -> key low 28 cycles, then done; no mark at any point.
REQ-036 SHALL test: code 40 -> one-cycle err, key stays low, no done, in_ready stays high.
REQ-037 SHALL test: rst_n pulsed low mid-dash of code 26 ('0') -> key low immediately; a subsequent 'E' encodes correctly.
REQ-038 SHALL test: in_valid held high with code 19 ('T') -> back-to-back characters, each key high 12, low 12, with a one-cycle IDLE between them.
